// File: rtl/gcd_req_arbiter_if.sv
// Request/response and engine-side signal bundle for gcd_req_arbiter.
// The slave modport is the arbiter's view; master is the clients'/engine's view.
interface gcd_req_arbiter_if #(
  parameter int unsigned NBITS = 256,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = NBITS + 3;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*NBITS-1:0] req_x;
  logic [NREQ*NBITS-1:0] req_y;
  logic [NREQ-1:0]       req_ready;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [1:0]            rsp_err;
  logic [NBITS-1:0]      rsp_gcd;
  logic [CW-1:0]         rsp_a;
  logic [CW-1:0]         rsp_b;

  logic                  eng_enable_p;
  logic [NBITS-1:0]      eng_x;
  logic [NBITS-1:0]      eng_y;
  logic [CW-1:0]         eng_a;
  logic [CW-1:0]         eng_b;
  logic [NBITS-1:0]      eng_gcd;
  logic                  eng_done_p;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
           eng_a, eng_b, eng_gcd, eng_done_p,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_gcd, rsp_a, rsp_b,
           eng_enable_p, eng_x, eng_y
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
           eng_a, eng_b, eng_gcd, eng_done_p,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_gcd, rsp_a, rsp_b,
           eng_enable_p, eng_x, eng_y
  );
endinterface

// File: rtl/gcd_req_arbiter.sv
// Round-robin front end sharing one extended-GCD engine among NREQ requesters,
// with zero-operand screening, a BUSY timeout and an ID-tagged response port.
module gcd_req_arbiter #(
  parameter int unsigned NBITS   = 256,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4 * NBITS + 16
) (
  input logic             clk,
  input logic             rst,
  gcd_req_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = NBITS + 3;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ZERO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [TW-1:0]    cnt;

  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [NBITS-1:0] grant_x;
  logic [NBITS-1:0] grant_y;

  // First requesting index after rr_ptr, wrapping modulo NREQ.
  always_comb begin : rr_pick
    logic [IDW-1:0] idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    grant_x = bus.req_x[32'(grant_idx) * NBITS +: NBITS];
    grant_y = bus.req_y[32'(grant_idx) * NBITS +: NBITS];
  end

  // Accept is a same-cycle pulse; forced low while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state == IDLE && grant_any) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rr_ptr           <= IDW'(NREQ - 1);
      cur_id           <= '0;
      cnt              <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= '0;
      bus.rsp_err      <= ERR_OK;
      bus.rsp_gcd      <= '0;
      bus.rsp_a        <= '0;
      bus.rsp_b        <= '0;
      bus.eng_enable_p <= 1'b0;
      bus.eng_x        <= '0;
      bus.eng_y        <= '0;
    end else begin
      bus.eng_enable_p <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            rr_ptr <= grant_idx;
            cur_id <= grant_idx;
            if (grant_x == '0 || grant_y == '0) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_id    <= grant_idx;
              bus.rsp_err   <= ERR_ZERO;
              bus.rsp_gcd   <= '0;
              bus.rsp_a     <= '0;
              bus.rsp_b     <= '0;
            end else begin
              // Operands stay on eng_x/eng_y until the next launch.
              state            <= LAUNCH;
              bus.eng_enable_p <= 1'b1;
              bus.eng_x        <= grant_x;
              bus.eng_y        <= grant_y;
            end
          end
        end

        LAUNCH: begin
          cnt   <= '0;
          state <= BUSY;
        end

        BUSY: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (bus.eng_done_p) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cur_id;
            bus.rsp_err   <= ERR_OK;
            bus.rsp_gcd   <= bus.eng_gcd;
            bus.rsp_a     <= CW'(bus.eng_a);
            bus.rsp_b     <= CW'(bus.eng_b);
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= cur_id;
            bus.rsp_err   <= ERR_TIMEOUT;
            bus.rsp_gcd   <= '0;
            bus.rsp_a     <= '0;
            bus.rsp_b     <= '0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter with a behavioural extended-GCD engine stub.
module tb_gcd_req_arbiter;
  localparam int NB  = 16;
  localparam int NR  = 4;
  localparam int CW  = NB + 3;
  localparam int TO  = 16;
  localparam int LAT = 3;

  logic clk;
  logic rst;

  gcd_req_arbiter_if #(.NBITS(NB), .NREQ(NR)) bus ();

  gcd_req_arbiter #(.NBITS(NB), .NREQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int done_cyc = 0;
  int left     = 0;
  bit active   = 1'b0;
  bit moved    = 1'b0;
  bit stuck    = 1'b0;
  logic [NB-1:0] sx, sy;

  function automatic void ext_gcd(input longint x, input longint y,
                                  output longint g, output longint a, output longint b);
    longint r0 = x, r1 = y, s0 = 1, s1 = 0, t0 = 0, t1 = 1, q, tmp;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = s0 - q * s1; s0 = s1; s1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
    end
    g = r0; a = s0; b = t0;
  endfunction

  function automatic bit ident(input logic [CW-1:0] a, input logic [CW-1:0] b,
                               input longint x, input longint y, input longint g);
    return (longint'($signed(a)) * x + longint'($signed(b)) * y) == g;
  endfunction

  // Engine stub: LAT cycles after a launch it pulses done, unless stuck.
  always @(posedge clk) begin : stub
    longint g, a, b;
    cyc <= cyc + 1;
    bus.eng_done_p <= 1'b0;
    if (bus.eng_enable_p) begin
      sx     <= bus.eng_x;
      sy     <= bus.eng_y;
      left   <= LAT;
      active <= !stuck;
      moved  <= 1'b0;
      en_cnt <= en_cnt + 1;
    end else if (active) begin
      if (bus.eng_x != sx || bus.eng_y != sy) moved <= 1'b1;
      if (left == 1) begin
        ext_gcd(longint'(sx), longint'(sy), g, a, b);
        bus.eng_gcd    <= NB'(g);
        bus.eng_a      <= CW'(a);
        bus.eng_b      <= CW'(b);
        bus.eng_done_p <= 1'b1;
        done_cyc       <= cyc + 1;
        active         <= 1'b0;
      end
      left <= left - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {bus.req_ready, bus.rsp_valid, bus.eng_enable_p, bus.rsp_id, bus.rsp_err}, '0);
    chk({tag, "_rsp"}, {bus.rsp_gcd, bus.rsp_a, bus.rsp_b}, '0);
    chk({tag, "_eng"}, {bus.eng_x, bus.eng_y}, '0);
  endtask

  task automatic set_req(input int id, input logic [NB-1:0] x, input logic [NB-1:0] y);
    bus.req_x[id*NB +: NB] = x;
    bus.req_y[id*NB +: NB] = y;
    bus.req_valid[id]      = 1'b1;
  endtask

  task automatic wait_grant(output int t, output logic [NR-1:0] g);
    int n = 0;
    #1;
    while (bus.req_ready == '0 && n < 60) begin
      tick();
      n++;
    end
    t = cyc;
    g = bus.req_ready;
    chk("grant_wait", 64'(bus.req_ready != '0), 1);
  endtask

  task automatic wait_rsp(output int t);
    int n = 0;
    while (!bus.rsp_valid && n < 80) begin
      tick();
      n++;
    end
    t = cyc;
    chk("rsp_wait", bus.rsp_valid, 1);
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  int ord[5] = '{0, 1, 2, 3, 0};
  logic [NB-1:0] xs[4] = '{16'd35, 16'd9, 16'd17, 16'd100};
  logic [NB-1:0] ys[4] = '{16'd12, 16'd28, 16'd5, 16'd27};

  initial begin
    int t, tr, th, en0, id;
    logic [NR-1:0] g;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();
    chk_quiet("post_reset");

    // All four requesting: round-robin from requester 0.
    for (int i = 0; i < NR; i++) set_req(i, xs[i], ys[i]);
    for (int k = 0; k < 5; k++) begin
      id  = ord[k];
      en0 = en_cnt;
      wait_grant(t, g);
      chk($sformatf("rr%0d_grant", k), g, 64'(1) << id);
      wait_rsp(tr);
      chk($sformatf("rr%0d_id", k), bus.rsp_id, id);
      chk($sformatf("rr%0d_err", k), bus.rsp_err, 0);
      chk($sformatf("rr%0d_gcd", k), bus.rsp_gcd, 1);
      chk($sformatf("rr%0d_ident", k), ident(bus.rsp_a, bus.rsp_b, longint'(xs[id]), longint'(ys[id]), 1), 1);
      chk($sformatf("rr%0d_launches", k), en_cnt, en0 + 1);
      chk($sformatf("rr%0d_done_lat", k), tr, done_cyc + 1);
      consume();
      if (k == 4) bus.req_valid = '0;
    end

    // req0 12/8: launch timing, held operands, result.
    set_req(0, 16'd12, 16'd8);
    en0 = en_cnt;
    wait_grant(t, g);
    chk("t1_grant", g, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("t1_enable", bus.eng_enable_p, 1);
    chk("t1_eng_ops", {bus.eng_x, bus.eng_y}, {16'd12, 16'd8});
    tick();
    chk("t1_enable_off", bus.eng_enable_p, 0);
    wait_rsp(tr);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_err", bus.rsp_err, 0);
    chk("t1_gcd", bus.rsp_gcd, 4);
    chk("t1_ident", ident(bus.rsp_a, bus.rsp_b, 12, 8, 4), 1);
    chk("t1_done_lat", tr, done_cyc + 1);
    chk("t1_ops_held", moved, 0);
    chk("t1_launches", en_cnt, en0 + 1);
    consume();
    chk("t1_rsp_drop", bus.rsp_valid, 0);

    // req2 zero operand: immediate error response, no launch.
    set_req(2, 16'd0, 16'd5);
    en0 = en_cnt;
    wait_grant(t, g);
    chk("t2_grant", g, 4'b0100);
    tick();
    bus.req_valid = '0;
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_err", bus.rsp_err, 2'b01);
    chk("t2_id", bus.rsp_id, 2);
    chk("t2_zero", {bus.rsp_gcd, bus.rsp_a, bus.rsp_b}, 0);
    chk("t2_no_enable", bus.eng_enable_p, 0);
    consume();
    chk("t2_launches", en_cnt, en0);

    // Stuck engine: timeout response at T+2+TIMEOUT, then normal op.
    stuck = 1'b1;
    set_req(1, 16'd14, 16'd6);
    wait_grant(t, g);
    chk("t4_grant", g, 4'b0010);
    tick();
    bus.req_valid = '0;
    wait_rsp(tr);
    chk("t4_rsp_time", tr, t + 2 + TO);
    chk("t4_err", bus.rsp_err, 2'b10);
    chk("t4_id", bus.rsp_id, 1);
    chk("t4_zero", {bus.rsp_gcd, bus.rsp_a, bus.rsp_b}, 0);
    stuck = 1'b0;
    consume();
    set_req(3, 16'd35, 16'd21);
    wait_grant(t, g);
    chk("t4b_grant", g, 4'b1000);
    tick();
    bus.req_valid = '0;
    wait_rsp(tr);
    chk("t4b_err", bus.rsp_err, 0);
    chk("t4b_gcd", bus.rsp_gcd, 7);
    chk("t4b_id", bus.rsp_id, 3);
    chk("t4b_ident", ident(bus.rsp_a, bus.rsp_b, 35, 21, 7), 1);
    consume();

    // Back-pressure: response held 5 cycles, req1 waits for the handshake.
    set_req(0, 16'd48, 16'd18);
    set_req(1, 16'd7, 16'd0);
    wait_grant(t, g);
    chk("t5_grant", g, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    wait_rsp(tr);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d_valid", i), bus.rsp_valid, 1);
      chk($sformatf("t5_hold%0d_fields", i), {bus.rsp_id, bus.rsp_err, bus.rsp_gcd}, {2'd0, 2'b00, 16'd6});
      chk($sformatf("t5_hold%0d_ident", i), ident(bus.rsp_a, bus.rsp_b, 48, 18, 6), 1);
      chk($sformatf("t5_hold%0d_noready", i), bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t5_hs_noready", bus.req_ready, 0);
    th = cyc;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t5_after_hs_valid", bus.rsp_valid, 0);
    chk("t5_next_grant", bus.req_ready, 4'b0010);
    chk("t5_next_grant_cyc", cyc, th + 1);
    tick();
    bus.req_valid = '0;
    chk("t5b_err", bus.rsp_err, 2'b01);
    chk("t5b_id", bus.rsp_id, 1);
    consume();

    // Reset mid-BUSY: outputs clear at once, op dropped, late done ignored.
    set_req(2, 16'd12, 16'd18);
    wait_grant(t, g);
    chk("t6_grant", g, 4'b0100);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_quiet("t6_rst");
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t6_quiet%0d", i), {bus.rsp_valid, bus.eng_enable_p}, 0);
    end
    set_req(0, 16'd9, 16'd6);
    set_req(3, 16'd5, 16'd3);
    wait_grant(t, g);
    chk("t6b_grant", g, 4'b0001);
    tick();
    bus.req_valid = '0;
    wait_rsp(tr);
    chk("t6b_id", bus.rsp_id, 0);
    chk("t6b_err", bus.rsp_err, 0);
    chk("t6b_gcd", bus.rsp_gcd, 3);
    chk("t6b_ident", ident(bus.rsp_a, bus.rsp_b, 9, 6, 3), 1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/gcd_req_arbiter.md
# gcd_req_arbiter

Shares one binary extended-GCD engine among NREQ requesters. Round-robin arbitration, operand capture and hold, engine launch, completion capture, timeout and zero-operand screening, and a valid/ready response port tagged with the requester ID. Sits between the modular-inverse and key-setup clients and the single GCD datapath instance.

## Interface
- NBITS, 256, operand width; engine coefficient width is NBITS+3 (signed, two's complement)
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ)
- TIMEOUT, 4*NBITS+16, maximum BUSY cycles before abort
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_x, req_y  in  NREQ*NBITS each  flattened operands; requester i at [i*NBITS +: NBITS]
- req_ready  out  NREQ  one-hot grant/accept pulse
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  IDW  requester index of response
- rsp_err  out  2  00 ok, 01 zero operand, 10 timeout
- rsp_gcd  out  NBITS;  rsp_a, rsp_b  out  NBITS+3  result, with rsp_a*x + rsp_b*y = rsp_gcd
- eng_enable_p  out  1  one-cycle start pulse to engine
- eng_x, eng_y  out  NBITS  engine operands
- eng_a, eng_b  in  NBITS+3;  eng_gcd  in  NBITS;  eng_done_p  in  1  engine results and one-cycle done pulse

## Operation
- States: IDLE, LAUNCH, BUSY, RESP.
- IDLE: if any req_valid, grant the first set bit searching from rr_ptr+1 (mod NREQ). Assert req_ready[g] combinationally the same cycle. Latch g, req_x[g], req_y[g] into op_x/op_y/cur_id. Set rr_ptr <= g.
  - If either operand is zero, go to RESP with err=01, gcd/a/b=0; the engine is not launched.
  - Otherwise go to LAUNCH.
- LAUNCH: eng_enable_p=1 for exactly one cycle. Clear timeout counter. Go to BUSY.
- BUSY:
  - Count cycles.
  - On eng_done_p: capture eng_gcd/eng_a/eng_b and set err=00. Go to RESP.
  - When the count reaches TIMEOUT without done: err=10, gcd/a/b=0. Go to RESP.
- RESP: rsp_valid=1, all rsp_* fields stable. On rsp_valid && rsp_ready, go to IDLE.
- eng_x/eng_y are driven from op_x/op_y and held constant from LAUNCH until the controller leaves BUSY. The engine reads the operands every iteration, so they must not change mid-operation.
- eng_done_p arriving outside BUSY is ignored.
- After a timeout, the engine is not reset. The next LAUNCH pulse reloads it.
- Coefficients pass through as raw bits and are never resized or sign-adjusted.

## Timing
- Reset values: state=IDLE, rr_ptr=NREQ-1 (requester 0 has first priority). All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_err, rsp_gcd, rsp_a, rsp_b, eng_enable_p, eng_x, eng_y.
- Acceptance at edge T (req_ready high in cycle T). eng_enable_p is high in cycle T+1. BUSY starts at T+2.
- eng_done_p in cycle D gives rsp_valid from cycle D+1. Zero operand accepted at T gives rsp_valid from T+1.
- Timeout: with no done, rsp_valid from T+2+TIMEOUT.
- The earliest next grant is the cycle after the rsp handshake; there is no overlap of operations.
- Requests arriving while not in IDLE are held by the requester. req_ready stays 0 outside IDLE.
- Simultaneous eng_done_p and timeout-count terminal in the same cycle: done wins, err=00.
- rst asserted in any state returns to IDLE within the same cycle, with all outputs at reset values. An in-flight operation is dropped and no response is produced.

## Test plan
- req0 x=12, y=8 -> rsp_id=0, err=00, rsp_gcd=4, rsp_a*12+rsp_b*8=4. eng_x/eng_y stay constant 12/8 throughout BUSY.
- req2 x=0, y=5 -> rsp_valid at T+1, err=01, gcd=0. eng_enable_p never asserts.
- All four req_valid held high with distinct coprime operands -> grant order 0,1,2,3,0. Each rsp_id matches its grant. Exactly one eng_enable_p per operation.
- Engine stub that never pulses done, TIMEOUT=16 -> err=10, rsp_valid at T+18. A following request (x=35, y=21) returns gcd=7, err=00.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable, no req_ready asserted. Handshake on cycle 6, next grant on cycle 7.
- rst pulsed mid-BUSY -> all outputs 0 immediately, no response emitted. A fresh request completes normally, starting from requester 0 priority.
